spi_led_scheduler: RTL and testbench
====================================

Name: spi_led_scheduler

Overview:
- Frame-level sequencer in front of the byte-wide SPI master that drives the LED driver chain (MAX7219-style 16-bit address/data frames).
- After reset, plays a fixed 4-frame driver init sequence.
- Then arbitrates round-robin between two frame requesters and sends each frame as two bytes, MSB byte first, through the SPI master's start/done handshake.
- Enforces a minimum inter-frame gap and a per-byte timeout.

Parameters:
- GAP_CYCLES, 4: idle clk cycles between the last byte's spi_done and the next frame's first spi_start; range 1..255.
- TIMEOUT_CYCLES, 1024: clk cycles to wait for spi_done per byte before abort; range 2..65535.
- INTENSITY, 8'h07: data byte of init frame 3.
- SCAN_LIMIT, 8'h07: data byte of init frame 1.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-low reset.
- req0  in  1  requester 0 frame request; held high with frame0 stable until ack0.
- frame0  in  16  requester 0 frame: [15:8] address, [7:0] data.
- ack0  out  1  one-cycle pulse; frame0 has been latched.
- req1  in  1  requester 1 frame request; same rules as req0.
- frame1  in  16  requester 1 frame.
- ack1  out  1  one-cycle pulse; frame1 has been latched.
- spi_start  out  1  one-cycle pulse to SPI master: send spi_data.
- spi_data  out  8  byte to SPI master; stable from the spi_start cycle until spi_done.
- spi_done  in  1  one-cycle pulse from SPI master: byte finished, SS released.
- busy  out  1  high whenever state is not IDLE.
- init_done  out  1  high after the init sequence completes; stays high until reset.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- Reset (reset==0 at a clk edge):
  - All outputs 0.
  - State INIT_LOAD, init index 0.
  - Round-robin pointer last=1, so requester 0 wins the first tie.
  - Reset mid-frame abandons the frame immediately; no further spi_start is issued.
- States: INIT_LOAD, IDLE, SEND_HI, WAIT_HI, SEND_LO, WAIT_LO, GAP.
- Init table (index: {addr,data}):
  - 0: {0x0C,0x01}
  - 1: {0x0B,SCAN_LIMIT}
  - 2: {0x09,0x00}
  - 3: {0x0A,INTENSITY}
- INIT_LOAD: latch table[index] into the frame register, go to SEND_HI. No ack is issued.
- IDLE:
  - Only one req high: grant that requester.
  - Both high: grant the requester not equal to last.
  - On grant: latch frame, pulse ackN on the next cycle (registered), update last, go to SEND_HI.
  - No req: stay in IDLE.
  - req is sampled only in IDLE with init_done=1. Requests raised during INIT or during a transfer wait, unacked.
- SEND_HI: spi_start=1 for exactly this cycle, spi_data=frame[15:8], clear timeout counter, go to WAIT_HI.
- WAIT_HI: spi_done goes to SEND_LO; otherwise increment the timeout counter.
- SEND_LO: spi_start=1 for one cycle, spi_data=frame[7:0], go to WAIT_LO.
- WAIT_LO: spi_done goes to GAP.
- Latency:
  - req seen in IDLE at cycle N: ack at N+1.
  - First spi_start at N+1.
  - Second spi_start one cycle after the first spi_done.
- Timeout (WAIT_HI/WAIT_LO):
  - If the counter reaches TIMEOUT_CYCLES-1 without spi_done: set err, abandon the frame (low byte not sent if aborted in WAIT_HI), go to GAP.
  - A timed-out requester frame has already been acked and is not retried.
  - A timed-out init frame counts as sent.
- GAP:
  - Count GAP_CYCLES cycles, then:
    - if init_done=0 and index<3: index+1, go to INIT_LOAD;
    - if init_done=0 and index==3: set init_done, go to IDLE;
    - otherwise go to IDLE.
  - The gap is counted from the cycle after spi_done.
- spi_done outside WAIT_HI/WAIT_LO is ignored.
- spi_done arriving in the same cycle the timeout fires: done wins; err is not set.
- ack0 and ack1 are never high together; at most one ack per frame.
- busy=0 only in IDLE. busy is 1 throughout INIT.

Test Plan:
1. Release reset with a responder pulsing spi_done 10 cycles after each spi_start:
   - spi_data sequence 0C,01,0B,07,09,00,0A,07.
   - init_done rises GAP_CYCLES cycles after the 8th spi_done.
   - No ack during init.
2. After init, req0=1 with frame0=16'h0155:
   - ack0 pulses one cycle after sampling; spi_data 01 then 55.
   - Second spi_start one cycle after the first spi_done.
   - busy returns to 0 after GAP_CYCLES.
3. req0 and req1 both held high continuously with different frames:
   - Grants alternate 0,1,0,1 starting with 0.
   - Consecutive frames are separated by at least GAP_CYCLES idle cycles.
4. Responder withholds spi_done on a high byte:
   - err=1 exactly TIMEOUT_CYCLES-1 cycles after the WAIT_HI counter clear.
   - The low byte is not sent.
   - The next request is still served; err stays 1.
5. Assert reset during WAIT_LO:
   - All outputs 0 on the next cycle.
   - Init sequence restarts from 0x0C.
   - Stray spi_done pulses in IDLE cause no state change.
6. spi_done coincident with the timeout cycle:
   - err stays 0 and the frame completes normally.

Source files
------------

// File: rtl/spi_led_scheduler.sv
// spi_led_scheduler: frame sequencer in front of a byte-wide SPI master.
// Plays a 4-frame LED-driver init sequence after reset, then serves two
// round-robin frame requesters. Each 16-bit frame goes out as two bytes,
// high byte first. A minimum gap is kept between frames, and each byte
// has a timeout.
// Timing: the per-byte counter is cleared on the edge that leaves
// SEND_x. The timeout fires on the edge where it would reach
// TIMEOUT_CYCLES-1, so a byte waits at most TIMEOUT_CYCLES-1 cycles.
// GAP lasts GAP_CYCLES cycles, starting the cycle after the last spi_done.
module spi_led_scheduler #(
  parameter int         GAP_CYCLES     = 4,
  parameter int         TIMEOUT_CYCLES = 1024,
  parameter logic [7:0] INTENSITY      = 8'h07,
  parameter logic [7:0] SCAN_LIMIT     = 8'h07
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic [15:0] frame0,
  output logic        ack0,
  input  logic        req1,
  input  logic [15:0] frame1,
  output logic        ack1,
  output logic        spi_start,
  output logic [7:0]  spi_data,
  input  logic        spi_done,
  output logic        busy,
  output logic        init_done,
  output logic        err
);

  localparam logic [15:0] TO_LAST  = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  GAP_LAST = 8'(GAP_CYCLES - 1);

  typedef enum logic [2:0] {
    S_INIT_LOAD, S_IDLE, S_SEND_HI, S_WAIT_HI, S_SEND_LO, S_WAIT_LO, S_GAP
  } state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic        r_last;
  logic [15:0] r_frame;
  logic [15:0] r_to_cnt;
  logic [7:0]  r_gap_cnt;
  logic        r_ack0, r_ack1, r_spi_start, r_busy, r_init_done, r_err;
  logic [7:0]  r_spi_data;

  logic        w_grant1;
  logic [15:0] w_gnt_frame;
  logic [15:0] w_init_frame;
  logic [15:0] w_to_nxt;
  logic        w_timeout;

  // Init table lookup for the current index
  always_comb begin
    w_init_frame = 16'h0;
    case (r_idx)
      2'd0: w_init_frame = {8'h0C, 8'h01};
      2'd1: w_init_frame = {8'h0B, SCAN_LIMIT};
      2'd2: w_init_frame = {8'h09, 8'h00};
      2'd3: w_init_frame = {8'h0A, INTENSITY};
      default: w_init_frame = 16'h0;
    endcase
  end

  // Round-robin: requester 1 wins if alone, or on a tie when 0 went last
  assign w_grant1    = req1 & (~req0 | ~r_last);
  assign w_gnt_frame = w_grant1 ? frame1 : frame0;
  assign w_to_nxt    = r_to_cnt + 16'd1;
  assign w_timeout   = (w_to_nxt == TO_LAST);

  // Sequencer FSM; all outputs registered
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_INIT_LOAD;
      r_idx       <= 2'd0;
      r_last      <= 1'b1;
      r_frame     <= 16'h0;
      r_to_cnt    <= 16'h0;
      r_gap_cnt   <= 8'h0;
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_spi_start <= 1'b0;
      r_spi_data  <= 8'h0;
      r_busy      <= 1'b0;
      r_init_done <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_ack0      <= 1'b0;
      r_ack1      <= 1'b0;
      r_spi_start <= 1'b0;
      case (r_state)
        S_INIT_LOAD: begin
          r_frame     <= w_init_frame;
          r_spi_data  <= w_init_frame[15:8];
          r_spi_start <= 1'b1;
          r_busy      <= 1'b1;
          r_state     <= S_SEND_HI;
        end
        S_IDLE: begin
          if (r_init_done && (req0 || req1)) begin
            r_frame     <= w_gnt_frame;
            r_spi_data  <= w_gnt_frame[15:8];
            r_spi_start <= 1'b1;
            r_ack0      <= ~w_grant1;
            r_ack1      <= w_grant1;
            r_last      <= w_grant1;
            r_busy      <= 1'b1;
            r_state     <= S_SEND_HI;
          end
        end
        S_SEND_HI: begin
          r_to_cnt <= 16'h0;
          r_state  <= S_WAIT_HI;
        end
        S_WAIT_HI: begin
          if (spi_done) begin
            r_spi_data  <= r_frame[7:0];
            r_spi_start <= 1'b1;
            r_state     <= S_SEND_LO;
          end else if (w_timeout) begin
            r_err     <= 1'b1;
            r_gap_cnt <= 8'h0;
            r_state   <= S_GAP;
          end else begin
            r_to_cnt <= w_to_nxt;
          end
        end
        S_SEND_LO: begin
          r_to_cnt <= 16'h0;
          r_state  <= S_WAIT_LO;
        end
        S_WAIT_LO: begin
          if (spi_done) begin
            r_gap_cnt <= 8'h0;
            r_state   <= S_GAP;
          end else if (w_timeout) begin
            r_err     <= 1'b1;
            r_gap_cnt <= 8'h0;
            r_state   <= S_GAP;
          end else begin
            r_to_cnt <= w_to_nxt;
          end
        end
        S_GAP: begin
          if (r_gap_cnt == GAP_LAST) begin
            if (!r_init_done && r_idx != 2'd3) begin
              r_idx   <= r_idx + 2'd1;
              r_state <= S_INIT_LOAD;
            end else begin
              r_init_done <= 1'b1;
              r_busy      <= 1'b0;
              r_state     <= S_IDLE;
            end
          end else begin
            r_gap_cnt <= r_gap_cnt + 8'd1;
          end
        end
        default: r_state <= S_INIT_LOAD;
      endcase
    end
  end

  assign ack0      = r_ack0;
  assign ack1      = r_ack1;
  assign spi_start = r_spi_start;
  assign spi_data  = r_spi_data;
  assign busy      = r_busy;
  assign init_done = r_init_done;
  assign err       = r_err;

endmodule

// File: tb/tb_spi_led_scheduler.sv
// Directed bench for spi_led_scheduler: init sequence, single and
// round-robin frames, timeout abort, reset mid-frame, and done on the timeout cycle.
module tb_spi_led_scheduler;
  localparam int G = 4;
  localparam int T = 1024;

  logic        clk = 1'b0, reset = 1'b0;
  logic        req0 = 1'b0, req1 = 1'b0;
  logic [15:0] frame0 = 16'h0, frame1 = 16'h0;
  logic        ack0, ack1, spi_start, busy, init_done, err, spi_done;
  logic [7:0]  spi_data;

  logic resp_fire = 1'b0, resp_hold = 1'b0, stray = 1'b0;
  int   resp_delay = 10;
  int   resp_cnt = 0;
  assign spi_done = resp_fire | stray;

  int n_chk = 0, n_fail = 0;
  int cyc = 0;

  typedef struct { int cyc; logic [7:0] d; } start_t;
  typedef struct { int cyc; int who; } ack_t;
  start_t start_q[$];
  ack_t   ack_q[$];
  int     done_q[$];
  int     init_rise = -1, busy_fall = -1, err_rise = -1;
  logic   p_init = 1'b0, p_busy = 1'b0, p_err = 1'b0, both_ack = 1'b0;

  spi_led_scheduler #(.GAP_CYCLES(G), .TIMEOUT_CYCLES(T),
                      .INTENSITY(8'h07), .SCAN_LIMIT(8'h07)) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .frame0(frame0), .ack0(ack0),
    .req1(req1), .frame1(frame1), .ack1(ack1),
    .spi_start(spi_start), .spi_data(spi_data), .spi_done(spi_done),
    .busy(busy), .init_done(init_done), .err(err)
  );

  always #5 clk = ~clk;

  // cycle numbering and spi_done log, as the DUT samples them
  always @(posedge clk) begin
    if (spi_done) done_q.push_back(cyc);
    cyc = cyc + 1;
  end

  // SPI responder: pulses done resp_delay cycles after each spi_start
  always @(negedge clk) begin
    resp_fire = 1'b0;
    if (!reset) resp_cnt = 0;
    else begin
      if (resp_cnt > 0) begin
        resp_cnt = resp_cnt - 1;
        if (resp_cnt == 0) resp_fire = 1'b1;
      end
      if (spi_start && !resp_hold) resp_cnt = resp_delay;
    end
  end

  // output event monitor
  always @(negedge clk) begin
    if (spi_start) start_q.push_back('{cyc, spi_data});
    if (ack0) ack_q.push_back('{cyc, 0});
    if (ack1) ack_q.push_back('{cyc, 1});
    if (ack0 && ack1) both_ack = 1'b1;
    if (init_done && !p_init) init_rise = cyc;
    if (!busy && p_busy) busy_fall = cyc;
    if (err && !p_err) err_rise = cyc;
    p_init = init_done; p_busy = busy; p_err = err;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  function automatic logic [7:0] st_d(int i);
    return (i < start_q.size()) ? start_q[i].d : 8'hxx;
  endfunction
  function automatic int st_c(int i);
    return (i < start_q.size()) ? start_q[i].cyc : -1;
  endfunction
  function automatic int dn(int i);
    return (i < done_q.size()) ? done_q[i] : -1000;
  endfunction

  task automatic clear_logs();
    start_q.delete(); ack_q.delete(); done_q.delete();
    init_rise = -1; busy_fall = -1; err_rise = -1;
  endtask

  task automatic wait_acks(input int n, input int max);
    for (int i = 0; i < max && ack_q.size() < n; i++) tick();
    chk("ack_count", ack_q.size(), n);
  endtask

  task automatic wait_idle(input int max);
    for (int i = 0; i < max && busy; i++) tick();
    chk("idle_reached", busy, 1'b0);
  endtask

  task automatic wait_init(input int max);
    for (int i = 0; i < max && !init_done; i++) tick();
    chk("init_done", init_done, 1'b1);
  endtask

  // one frame from a single requester, returns its request cycle
  task automatic send_one(input int who, input logic [15:0] f, output int rq);
    if (who == 0) begin frame0 = f; req0 = 1'b1; end
    else          begin frame1 = f; req1 = 1'b1; end
    rq = cyc;
    wait_acks(1, 20);
    req0 = 1'b0; req1 = 1'b0;
    wait_idle(3 * T);
  endtask

  logic [7:0] init_seq [8] = '{8'h0C, 8'h01, 8'h0B, 8'h07, 8'h09, 8'h00, 8'h0A, 8'h07};
  logic [7:0] exp_hi [4] = '{8'hAA, 8'hBB, 8'hAA, 8'hBB};

  initial begin
    int rq, gap, n_st;

    // reset values
    repeat (3) tick();
    chk("reset_outs", {spi_start, spi_data, ack0, ack1, busy, init_done, err}, 0);

    // 1: init sequence
    clear_logs();
    reset = 1'b1;
    wait_init(400);
    chk("init_nstart", start_q.size(), 8);
    for (int i = 0; i < 8; i++) chk($sformatf("init_byte%0d", i), st_d(i), init_seq[i]);
    chk("init_no_ack", ack_q.size(), 0);
    chk("init_lo_after_done", st_c(1), dn(0) + 1);
    // GAP spans the G cycles after the last done; init_done shows on the next
    chk("init_done_time", init_rise, dn(7) + G + 1);
    chk("init_busy_low", busy, 1'b0);

    // 2: single frame from requester 0
    clear_logs();
    send_one(0, 16'h0155, rq);
    chk("r0_ack_who", ack_q[0].who, 0);
    chk("r0_ack_time", ack_q[0].cyc, rq + 1);
    chk("r0_start_time", st_c(0), rq + 1);
    chk("r0_hi", st_d(0), 8'h01);
    chk("r0_lo", st_d(1), 8'h55);
    chk("r0_lo_after_done", st_c(1), dn(0) + 1);
    chk("r0_busy_fall", busy_fall, dn(1) + G + 1);

    // requester 1 alone; also leaves the pointer at 1
    clear_logs();
    send_one(1, 16'h0A0F, rq);
    chk("r1_ack_who", ack_q[0].who, 1);
    chk("r1_bytes", {st_d(0), st_d(1)}, 16'h0A0F);

    // 3: both requesters held high
    clear_logs();
    frame0 = 16'hAA01; frame1 = 16'hBB02;
    req0 = 1'b1; req1 = 1'b1;
    wait_acks(4, 600);
    req0 = 1'b0; req1 = 1'b0;
    wait_idle(3 * T);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("rr_who%0d", k), (k < ack_q.size()) ? ack_q[k].who : -1, k % 2);
      chk($sformatf("rr_hi%0d", k), st_d(2 * k), exp_hi[k]);
    end
    for (int k = 1; k < 4; k++) begin
      gap = st_c(2 * k) - dn(2 * k - 1) - 1;
      chk($sformatf("rr_gap%0d", k), gap >= G, 1'b1);
    end
    chk("rr_no_double_ack", both_ack, 1'b0);

    // 4: high byte never completes
    clear_logs();
    resp_hold = 1'b1;
    send_one(0, 16'h0C33, rq);
    chk("to_err_time", err_rise, st_c(0) + T);
    chk("to_no_lo", start_q.size(), 1);
    resp_hold = 1'b0;
    clear_logs();
    send_one(1, 16'h0344, rq);
    chk("to_next_bytes", {st_d(0), st_d(1)}, 16'h0344);
    chk("to_err_sticky", err, 1'b1);

    // 5: reset while waiting for the low byte
    clear_logs();
    frame0 = 16'h0266; req0 = 1'b1;
    wait_acks(1, 20);
    req0 = 1'b0;
    for (int i = 0; i < 40 && start_q.size() < 2; i++) tick();
    chk("rst_lo_sent", start_q.size(), 2);
    tick();
    reset = 1'b0;
    tick();
    chk("rst_outs", {spi_start, spi_data, ack0, ack1, busy, init_done, err}, 0);
    n_st = start_q.size();
    tick();
    chk("rst_no_start", start_q.size(), n_st);
    clear_logs();
    reset = 1'b1;
    wait_init(400);
    chk("rst_first_byte", st_d(0), 8'h0C);
    chk("rst_init_n", start_q.size(), 8);
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      stray = 1'b1; tick(); stray = 1'b0; tick(); tick();
    end
    chk("stray_no_start", start_q.size(), 0);
    chk("stray_idle", {busy, err}, 2'b00);
    send_one(0, 16'h0177, rq);
    chk("stray_then_frame", {st_d(0), st_d(1)}, 16'h0177);

    // 6: spi_done lands on the timeout cycle of each byte
    clear_logs();
    resp_delay = T - 1;
    send_one(0, 16'h0488, rq);
    chk("edge_bytes", {st_d(0), st_d(1)}, 16'h0488);
    chk("edge_n", start_q.size(), 2);
    chk("edge_err", err, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // hard stop so the run can never hang
  initial begin
    #2000000;
    $display("FAIL global_timeout: got %0d cycles expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
